sccb_target_regfile: RTL and testbench

//  SCCB/I2C target with 2-byte register addressing; the responder side of the camera config master.

---
 rtl/sccb_target_regfile.sv | 206 ++++++++++++++++++++
 tb/tb_sccb_target_regfile.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_target_regfile.sv
// sccb_target_regfile: SCCB/I2C target with a 16-bit register pointer,
// filtered bus inputs, a byte register array and a write strobe port.
module sccb_target_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         ADDR_W     = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, DEVADR, REGHI, REGLO, WRDATA, RDDATA
  } st_e;

  // bit 1 = SCL, bit 0 = SDA
  logic [1:0]         s1_q, s2_q, f_q, p_q;
  logic [1:0][CW-1:0] cnt_q;

  st_e         state_q, state_d, frame_nxt;
  logic [3:0]  bit_q;
  logic [6:0]  sh_q;
  logic        ack_q, rw_q, mack_q;
  logic [15:0] ptr_q;
  logic        oe_q;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        busy_q;
  logic [7:0]  mem_q [2**ADDR_W];

  logic        scl_rise, scl_fall, start, stop;
  logic        last_bit, dev_hit;
  logic [7:0]  byte_w;
  logic [15:0] ptr_inc;
  logic [7:0]  rd_cur;
  logic        rd_msb_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 2'b11;
      s2_q  <= 2'b11;
      f_q   <= 2'b11;
      p_q   <= 2'b11;
      cnt_q <= '0;
    end else begin
      s1_q <= {scl_i, sda_i};
      s2_q <= s1_q;
      p_q  <= f_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == f_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILTER_LEN - 1)) begin
          f_q[i]   <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign scl_rise = f_q[1] & ~p_q[1];
  assign scl_fall = ~f_q[1] & p_q[1];
  assign start    = f_q[1] & p_q[1] & p_q[0] & ~f_q[0];
  assign stop     = f_q[1] & p_q[1] & ~p_q[0] & f_q[0];

  assign byte_w     = {sh_q, f_q[0]};
  assign last_bit   = scl_rise && (bit_q == 4'd7);
  assign dev_hit    = (byte_w[7:1] == DEV_ADDR);
  assign ptr_inc    = ptr_q + 16'd1;
  assign rd_cur     = mem_q[ptr_q[ADDR_W-1:0]];
  assign rd_msb_nxt = mem_q[ptr_inc[ADDR_W-1:0]][7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    frame_nxt = state_q;
    unique case (state_q)
      DEVADR:  frame_nxt = rw_q ? RDDATA : REGHI;
      REGHI:   frame_nxt = REGLO;
      REGLO:   frame_nxt = WRDATA;
      RDDATA:  frame_nxt = mack_q ? IDLE : RDDATA;
      default: frame_nxt = state_q;
    endcase
    state_d = state_q;
    unique case (1'b1)
      start: state_d = DEVADR;
      stop:  state_d = IDLE;
      (state_q == DEVADR && last_bit && !dev_hit):
        state_d = IDLE;
      (state_q != IDLE && scl_fall && bit_q == 4'd9):
        state_d = frame_nxt;
      default: state_d = state_q;
    endcase
  end

  // bit_q: 0..8 data clocks, 9 once the acknowledge clock has risen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q     <= '0;
      sh_q      <= '0;
      ack_q     <= 1'b0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b0;
      ptr_q     <= '0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (start || stop) begin
        bit_q <= '0;
        oe_q  <= 1'b0;
        ack_q <= 1'b0;
        if (stop) busy_q <= 1'b0;
      end else if (state_q == IDLE) begin
        bit_q <= '0;
      end else begin
        if (scl_rise) begin
          if (bit_q < 4'd8) begin
            sh_q  <= byte_w[6:0];
            bit_q <= bit_q + 4'd1;
          end else if (bit_q == 4'd8) begin
            mack_q <= f_q[0];
            bit_q  <= 4'd9;
          end
        end
        if (last_bit) begin
          unique case (state_q)
            DEVADR: begin
              ack_q  <= dev_hit;
              rw_q   <= byte_w[0];
              busy_q <= dev_hit;
            end
            REGHI: begin
              ptr_q[15:8] <= byte_w;
              ack_q       <= 1'b1;
            end
            REGLO: begin
              ptr_q[7:0] <= byte_w;
              ack_q      <= 1'b1;
            end
            WRDATA: begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= ptr_q;
              wr_data_q <= byte_w;
              ack_q     <= 1'b1;
            end
            default: ack_q <= 1'b0;
          endcase
        end
        if (scl_fall) begin
          if (bit_q == 4'd8) begin
            oe_q <= ack_q;
          end else if (bit_q == 4'd9) begin
            bit_q <= '0;
            oe_q  <= 1'b0;
            unique case (state_q)
              DEVADR: if (rw_q) oe_q <= ~rd_cur[7];
              WRDATA: ptr_q <= ptr_inc;
              RDDATA: begin
                if (mack_q) begin
                  busy_q <= 1'b0;
                end else begin
                  ptr_q <= ptr_inc;
                  oe_q  <= ~rd_msb_nxt;
                end
              end
              default: ;
            endcase
          end else if (state_q == RDDATA && bit_q != 4'd0) begin
            oe_q <= ~rd_cur[3'd7 - bit_q[2:0]];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) mem_q[wr_addr_q[ADDR_W-1:0]] <= wr_data_q;
  end

  always_comb begin
    sda_oe  = oe_q;
    wr_en   = wr_en_q;
    wr_addr = wr_addr_q;
    wr_data = wr_data_q;
    busy    = busy_q;
  end

endmodule

// File: tb/tb_sccb_target_regfile.sv
// tb_sccb_target_regfile: bus-level master driving the SCCB target,
// checked against a byte-map and pointer model of the register file.
module tb_sccb_target_regfile;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_oe, wr_en, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int total = 0;
  int bad = 0;
  logic [23:0] wq[$];
  logic [23:0] eq[$];
  logic [7:0]  ref_mem [256];
  logic [15:0] mptr = '0;

  sccb_target_regfile dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line),
    .sda_oe(sda_oe), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && wr_en === 1'b1) wq.push_back({wr_addr, wr_data});

  task automatic hq(input int n = 1);
    repeat (10 * n) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    sda_m = 1; hq(); scl = 1; hq(); sda_m = 0; hq(); scl = 0;
  endtask

  task automatic stop_c();
    sda_m = 0; hq(); scl = 1; hq(); sda_m = 1; hq(2);
  endtask

  task automatic wbit(input logic b, input bit g);
    hq();
    if (g) begin
      @(posedge clk); #1 scl = 1;
      @(posedge clk); #1 scl = 0;
    end
    sda_m = b; hq(); scl = 1; hq();
    if (g) begin
      @(posedge clk); #1 sda_m = ~b;
      @(posedge clk); #1 sda_m = b;
    end
    hq(); scl = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit g,
                           output bit ack);
    for (int i = 7; i >= 0; i--) wbit(b[i], g);
    hq(); sda_m = 1; hq(); scl = 1; hq();
    ack = (sda_line === 1'b0);
    hq(); scl = 0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      hq(); sda_m = 1; hq(); scl = 1; hq();
      b[i] = sda_line;
      hq(); scl = 0;
    end
    hq(); sda_m = mack; hq(); scl = 1; hq(2); scl = 0;
  endtask

  task automatic wr_txn(input logic [15:0] a, input logic [7:0] d [4],
                        input int n, input bit g, output int acks);
    bit k;
    acks = 0;
    start_c();
    send_byte(8'h78, g, k);    acks += int'(k);
    send_byte(a[15:8], g, k);  acks += int'(k);
    send_byte(a[7:0], g, k);   acks += int'(k);
    for (int i = 0; i < n; i++) begin
      send_byte(d[i], g, k); acks += int'(k);
    end
    stop_c();
  endtask

  task automatic rd_txn(input logic [15:0] a, input bit set_a, input int n,
                        output logic [7:0] got [4], output int acks,
                        output logic oe_a);
    bit k;
    logic [7:0] t;
    acks = 0;
    for (int i = 0; i < 4; i++) got[i] = '0;
    start_c();
    if (set_a) begin
      send_byte(8'h78, 0, k);   acks += int'(k);
      send_byte(a[15:8], 0, k); acks += int'(k);
      send_byte(a[7:0], 0, k);  acks += int'(k);
      start_c();
    end
    send_byte(8'h79, 0, k); acks += int'(k);
    for (int i = 0; i < n; i++) begin
      read_byte(logic'(i == n - 1), t);
      got[i] = t;
    end
    hq();
    oe_a = sda_oe;
    stop_c();
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d [4],
                             input int n);
    logic [15:0] p;
    p = a;
    for (int i = 0; i < n; i++) begin
      eq.push_back({p, d[i]});
      ref_mem[p[7:0]] = d[i];
      p = p + 16'd1;
    end
    mptr = p;
  endtask

  task automatic test_reset();
    repeat (4) @(posedge clk);
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    total++; if (wr_addr !== 16'h0) begin bad++; $display("FAIL rst_wr_addr got=%h exp=0000", wr_addr); end
    total++; if (wr_data !== 8'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=00", wr_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    hq(2);
  endtask

  task automatic test_basic_write();
    bit k;
    int acks;
    logic [7:0] bytes [4];
    bytes = '{8'h78, 8'h30, 8'h08, 8'h82};
    wq.delete();
    acks = 0;
    start_c();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], 0, k);
      acks += int'(k);
      if (i == 0) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_on got=%b exp=1", busy); end
      end
    end
    stop_c();
    total++; if (acks != 4) begin bad++; $display("FAIL basic_acks got=%0d exp=4", acks); end
    total++; if (wq.size() != 1) begin bad++; $display("FAIL basic_wr_count got=%0d exp=1", wq.size()); end
    else if (wq[0] !== 24'h300882) begin total++; bad++; $display("FAIL basic_wr got=%h exp=300882", wq[0]); end
    else total++;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_off got=%b exp=0", busy); end
    ref_mem[8'h08] = 8'h82;
    mptr = 16'h3009;
  endtask

  task automatic test_nack_addr();
    bit k;
    int acks;
    logic [7:0] d [4];
    wq.delete(); eq.delete();
    start_c();
    send_byte(8'h7A, 0, k);
    total++; if (k !== 1'b0) begin bad++; $display("FAIL nack_addr_ack got=%b exp=0", k); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nack_busy got=%b exp=0", busy); end
    send_byte(8'h00, 0, k);
    total++; if (k !== 1'b0) begin bad++; $display("FAIL nack_ignored_ack got=%b exp=0", k); end
    stop_c();
    total++; if (wq.size() != 0) begin bad++; $display("FAIL nack_no_wr got=%0d exp=0", wq.size()); end
    d = '{8'hA5, 8'h00, 8'h00, 8'h00};
    wr_txn(16'h0010, d, 1, 0, acks);
    model_write(16'h0010, d, 1);
    total++; if (acks != 4) begin bad++; $display("FAIL nack_after_acks got=%0d exp=4", acks); end
    total++; if (wq.size() != eq.size()) begin bad++; $display("FAIL nack_after_count got=%0d exp=%0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      total++; if (wq[i] !== eq[i]) begin bad++; $display("FAIL nack_after_wr got=%h exp=%h", wq[i], eq[i]); end
    end
  endtask

  task automatic test_burst();
    int acks;
    logic [7:0] d [4];
    wq.delete(); eq.delete();
    d = '{8'h11, 8'h22, 8'h33, 8'h00};
    wr_txn(16'h00FF, d, 3, 0, acks);
    model_write(16'h00FF, d, 3);
    total++; if (acks != 6) begin bad++; $display("FAIL burst_acks got=%0d exp=6", acks); end
    total++; if (wq.size() != eq.size()) begin bad++; $display("FAIL burst_count got=%0d exp=%0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      total++; if (wq[i] !== eq[i]) begin bad++; $display("FAIL burst_wr%0d got=%h exp=%h", i, wq[i], eq[i]); end
    end
  endtask

  task automatic test_read();
    int acks;
    logic oe_a;
    logic [7:0] got [4];
    logic [7:0] e0, e1;
    wq.delete();
    rd_txn(16'h00FF, 1, 2, got, acks, oe_a);
    mptr = 16'h00FF;
    e0 = ref_mem[mptr[7:0]];
    mptr = mptr + 16'd1;
    e1 = ref_mem[mptr[7:0]];
    total++; if (acks != 4) begin bad++; $display("FAIL read_acks got=%0d exp=4", acks); end
    total++; if (got[0] !== e0) begin bad++; $display("FAIL read_b0 got=%h exp=%h", got[0], e0); end
    total++; if (got[1] !== e1) begin bad++; $display("FAIL read_b1 got=%h exp=%h", got[1], e1); end
    total++; if (oe_a !== 1'b0) begin bad++; $display("FAIL read_release got=%b exp=0", oe_a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy got=%b exp=0", busy); end
    total++; if (wq.size() != 0) begin bad++; $display("FAIL read_no_wr got=%0d exp=0", wq.size()); end
    rd_txn(16'h0000, 0, 1, got, acks, oe_a);
    e0 = ref_mem[mptr[7:0]];
    total++; if (got[0] !== e0) begin bad++; $display("FAIL read_cont got=%h exp=%h", got[0], e0); end
  endtask

  task automatic test_start_midbyte();
    bit k;
    int acks;
    logic [7:0] d [4];
    wq.delete(); eq.delete();
    start_c();
    send_byte(8'h78, 0, k);
    send_byte(8'h12, 0, k);
    send_byte(8'h34, 0, k);
    for (int i = 0; i < 5; i++) wbit(logic'($urandom_range(0, 1)), 0);
    d = '{8'h5A, 8'h00, 8'h00, 8'h00};
    wr_txn(16'h1234, d, 1, 0, acks);
    model_write(16'h1234, d, 1);
    total++; if (acks != 4) begin bad++; $display("FAIL midbyte_acks got=%0d exp=4", acks); end
    total++; if (wq.size() != eq.size()) begin bad++; $display("FAIL midbyte_count got=%0d exp=%0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      total++; if (wq[i] !== eq[i]) begin bad++; $display("FAIL midbyte_wr got=%h exp=%h", wq[i], eq[i]); end
    end
  endtask

  task automatic test_glitch();
    int acks;
    logic [7:0] d [4];
    wq.delete(); eq.delete();
    d[0] = 8'($urandom);
    d[1] = 8'($urandom);
    d[2] = 8'h00; d[3] = 8'h00;
    wr_txn(16'h400C, d, 2, 1, acks);
    model_write(16'h400C, d, 2);
    total++; if (acks != 5) begin bad++; $display("FAIL glitch_acks got=%0d exp=5", acks); end
    total++; if (wq.size() != eq.size()) begin bad++; $display("FAIL glitch_count got=%0d exp=%0d", wq.size(), eq.size()); end
    else foreach (eq[i]) begin
      total++; if (wq[i] !== eq[i]) begin bad++; $display("FAIL glitch_wr got=%h exp=%h", wq[i], eq[i]); end
    end
  endtask

  task automatic test_reset_ack();
    bit seen;
    int acks;
    logic oe_a;
    logic [7:0] got [4];
    logic [7:0] e0;
    wq.delete();
    start_c();
    for (int i = 7; i >= 0; i--) wbit(logic'((8'h78 >> i) & 8'h01), 0);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      if (sda_oe === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstack_drive got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstack_async got=%b exp=0", sda_oe); end
    hq(); scl = 1; hq(); sda_m = 1; hq();
    rst_n = 1'b1;
    hq(2);
    mptr = 16'h0000;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstack_busy got=%b exp=0", busy); end
    rd_txn(16'h0000, 0, 1, got, acks, oe_a);
    e0 = ref_mem[mptr[7:0]];
    total++; if (got[0] !== e0) begin bad++; $display("FAIL rstack_ptr got=%h exp=%h", got[0], e0); end
    total++; if (wq.size() != 0) begin bad++; $display("FAIL rstack_no_wr got=%0d exp=0", wq.size()); end
  endtask

  task automatic test_random();
    int acks, n;
    logic oe_a;
    logic [15:0] base;
    logic [7:0] d [4];
    logic [7:0] got [4];
    logic [7:0] e;
    for (int it = 0; it < 4; it++) begin
      wq.delete(); eq.delete();
      base = (it == 0) ? 16'hFFFE : 16'($urandom);
      n = (it == 0) ? 4 : $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
      wr_txn(base, d, n, 0, acks);
      model_write(base, d, n);
      total++; if (acks != 3 + n) begin bad++; $display("FAIL rnd%0d_wacks got=%0d exp=%0d", it, acks, 3 + n); end
      total++; if (wq.size() != eq.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, wq.size(), eq.size()); end
      else foreach (eq[i]) begin
        total++; if (wq[i] !== eq[i]) begin bad++; $display("FAIL rnd%0d_wr%0d got=%h exp=%h", it, i, wq[i], eq[i]); end
      end
      rd_txn(base, 1, n, got, acks, oe_a);
      mptr = base;
      total++; if (acks != 4) begin bad++; $display("FAIL rnd%0d_racks got=%0d exp=4", it, acks); end
      for (int i = 0; i < n; i++) begin
        e = ref_mem[mptr[7:0]];
        if (i < n - 1) mptr = mptr + 16'd1;
        total++; if (got[i] !== e) begin bad++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", it, i, got[i], e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_nack_addr();
    test_burst();
    test_read();
    test_start_midbyte();
    test_glitch();
    test_reset_ack();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
